spi_regfile_periph: RTL and testbench
=====================================

Name: spi_regfile_periph

Overview:
- Parametrised SPI mode-0 peripheral fronting a generic register file of NUM_REGS x DATA_W control registers. Supports write and read-back frames over copi/cipo.
- All SPI pins are oversampled in the clk domain and no logic is clocked by sclk.
- Sits between the chip pins and the PWM/output-enable logic. The register file is exported flattened; a write strobe lets consumers react to updates.

Parameters:
- NUM_REGS, 5, number of implemented registers; addresses 0..NUM_REGS-1.
- DATA_W, 8, register and data-phase width in bits.
- ADDR_W, 7, address field width; NUM_REGS <= 2**ADDR_W.
- SYNC_STAGES, 2, synchronizer flops per SPI input; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- sclk  input  1  SPI clock, CPOL=0, async to clk
- copi  input  1  controller-out data, async
- ncs  input  1  chip select, active-low, async
- cipo  output  1  peripheral-out data, MSB first
- cipo_oe  output  1  high while synchronized ncs is low
- regs_flat  output  NUM_REGS*DATA_W  register r at bits [r*DATA_W +: DATA_W]
- wr_strobe  output  1  one-clk pulse per committed write
- wr_addr  output  ADDR_W  address of the last committed write
- frame_err  output  1  one-clk pulse on aborted or invalid frame

Behaviour:
- Frame format: FRAME_LEN = 1+ADDR_W+DATA_W bits, MSB first: R/W bit (1=write), address, data. Default frame is 16 bits.
- Input path:
  - Each input passes through a SYNC_STAGES synchronizer plus one history flop for edge detection.
  - Synchronizer and history flops reset to ncs=1, sclk=0, copi=0.
  - The sclk rise/fall detection and the ncs fall/rise detection use the synchronized signals.
  - Requirement: sclk period >= 8 clk periods, and ncs setup/hold around sclk edges >= 4 clk periods.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE -> CMD on ncs fall. The bit counter clears and the shift register clears.
  - CMD: each sclk rise shifts in sync copi. After 1+ADDR_W bits, latch rw and addr and go to DATA.
    - On a read, load the read-shift register with regs[addr], or 0 if addr >= NUM_REGS.
  - DATA: each sclk rise shifts in a data bit. After DATA_W bits, go to DONE.
    - On a write with addr < NUM_REGS: update the register, set wr_addr=addr and pulse wr_strobe in the same clk edge as the last-bit detection. The new value appears on regs_flat on the next cycle.
    - On a write with addr >= NUM_REGS: no update, no strobe, frame_err pulse.
  - DONE: further sclk edges are ignored. Go to IDLE on ncs rise.
  - ncs rise in CMD or DATA: abort the frame, with no register change and no strobe. Pulse frame_err and go to IDLE.
  - ncs rise and last-bit sclk rise detected in the same clk: the frame completes normally (commit, no frame_err).
- cipo:
  - 0 outside a read DATA phase.
  - In a read DATA phase, on each detected sclk fall: cipo <= read_shift[MSB], then read_shift shifts left.
  - The fall after the last address bit therefore drives data MSB, which the controller samples on the next sclk rise.
  - Read frames never modify registers. The copi data bits are ignored.
- Reset, including mid-frame:
  - Outputs: regs_flat=0, wr_strobe=0, wr_addr=0, frame_err=0, cipo=0, cipo_oe=0.
  - Internal state: FSM in IDLE, counters 0.
  - A frame already in progress when reset releases is ignored until ncs goes high and then low again.
- Back-to-back frames: ncs may go high then low with a >= 4-clk gap; the second frame is decoded independently.

Test Plan:
- Write frame 0x84A5 (write, addr 4, data 0xA5) -> regs_flat[39:32]=0xA5, a single wr_strobe with wr_addr=4, all other registers 0.
- Write 0x803C to addr 0, then read frame 0x0000 -> cipo bits sampled on sclk rises 9-16 equal 0x3C; regs unchanged; no wr_strobe.
- Write addr 4, raise ncs after 10 bits -> addr-4 register keeps its old value, one frame_err pulse, no wr_strobe.
- Write 0x85FF (addr 5 >= NUM_REGS) -> no register change, frame_err pulse; read of addr 5 returns 0x00.
- Write 0x8111 then 0x8322 back-to-back with a 4-clk ncs-high gap, and 20 sclk pulses in the second frame -> reg1=0x11, reg3=0x22, exactly two strobes, extra bits ignored.
- Assert rst_n low during bit 12 of a write -> all outputs 0; release with ncs still low and sclk toggling -> no write until the next complete ncs-framed transfer.

Source files
------------

// File: rtl/spi_regfile_periph.sv
`timescale 1ns/1ps
// spi_regfile_periph: SPI mode-0 peripheral (clk-oversampled) fronting a NUM_REGS x DATA_W register file
//   clk, rst_n         : system clock, async active-low reset
//   sclk, copi, ncs    : async SPI inputs (CPOL=0, ncs active-low)
//   cipo, cipo_oe      : peripheral data out (MSB first), driver enable while selected
//   regs_flat          : register r at [r*DATA_W +: DATA_W]
//   wr_strobe, wr_addr : one-clk pulse per committed write, address of last write
//   frame_err          : one-clk pulse on aborted frame or write to an unimplemented address
module spi_regfile_periph #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int SW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  logic [SYNC_STAGES:0]   sclk_q, sclk_d, ncs_q, ncs_d;
  logic [SYNC_STAGES-1:0] copi_q, copi_d;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;
  logic                   started_q, armed_q, armed_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-2:0]          shift_q, shift_d;
  logic [SW-1:0]          shift_in;
  logic                   rw_q, rw_d, addr_ok;
  logic [ADDR_W-1:0]      addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      rshift_q, rshift_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];
  logic                   cipo_q, cipo_d, wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;
  // top bit of each chain is the history flop used only for edge detection
  assign sclk_d    = {sclk_q[SYNC_STAGES-1:0], sclk};
  assign ncs_d     = {ncs_q[SYNC_STAGES-1:0], ncs};
  assign copi_d    = {copi_q[SYNC_STAGES-2:0], copi};
  assign copi_s    = copi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign ncs_rise  = ncs_q[SYNC_STAGES-1] & ~ncs_q[SYNC_STAGES];
  // a frame in progress at reset release must not look like a fresh ncs fall:
  // only arm once the whole ncs chain has been seen high after the reset values flushed
  assign ncs_fall  = armed_q & ~ncs_q[SYNC_STAGES-1] & ncs_q[SYNC_STAGES];
  assign armed_d   = armed_q | (started_q & (&ncs_q));
  assign shift_in  = {shift_q, copi_s};
  assign addr_ok   = int'(addr_q) < NUM_REGS;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    rshift_d    = rshift_q;
    regs_d      = regs_q;
    cipo_d      = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: if (ncs_fall) begin
        state_d = CMD;
        cnt_d   = '0;
        shift_d = '0;
      end
      CMD: if (ncs_rise) begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
      end else if (sclk_rise) begin
        shift_d = shift_in[SW-2:0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(ADDR_W)) begin
          state_d  = DATA;
          rw_d     = shift_in[ADDR_W];
          addr_d   = shift_in[ADDR_W-1:0];
          rshift_d = '0;
          for (int r = 0; r < NUM_REGS; r++)
            if (shift_in[ADDR_W-1:0] == ADDR_W'(r)) rshift_d = regs_q[r];
        end
      end
      DATA: if (sclk_rise && cnt_q == CW'(FRAME_LEN - 1)) begin
        // last bit wins over a simultaneous ncs rise
        state_d = ncs_rise ? IDLE : DONE;
        if (rw_q && addr_ok) begin
          for (int r = 0; r < NUM_REGS; r++)
            if (addr_q == ADDR_W'(r)) regs_d[r] = shift_in[DATA_W-1:0];
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
        end else begin
          frame_err_d = rw_q;
        end
      end else if (ncs_rise) begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
      end else begin
        shift_d = sclk_rise ? shift_in[SW-2:0] : shift_q;
        cnt_d   = sclk_rise ? cnt_q + CW'(1) : cnt_q;
        cipo_d  = rw_q ? 1'b0 : sclk_fall ? rshift_q[DATA_W-1] : cipo_q;
        if (!rw_q && sclk_fall) rshift_d = rshift_q << 1;
      end
      DONE: if (ncs_rise) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      ncs_q       <= '1;
      copi_q      <= '0;
      started_q   <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      rshift_q    <= '0;
      regs_q      <= '{default: '0};
      cipo_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      ncs_q       <= ncs_d;
      copi_q      <= copi_d;
      started_q   <= 1'b1;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      rshift_q    <= rshift_d;
      regs_q      <= regs_d;
      cipo_q      <= cipo_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end
  assign cipo      = cipo_q;
  assign cipo_oe   = ~ncs_q[SYNC_STAGES-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_regfile_periph.sv
`timescale 1ns/1ps
// tb_spi_regfile_periph: table-driven SPI frames plus hand sequences for back-to-back and mid-frame reset
module tb_spi_regfile_periph;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        ncs = 1'b1;
  logic        cipo, cipo_oe, wr_strobe, frame_err;
  logic [39:0] regs_flat;
  logic [6:0]  wr_addr;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          n_err = 0;
  typedef struct {
    logic [15:0] tx;
    int          nbits;
    logic [39:0] regs;
    int          wr;
    int          err;
    logic [6:0]  waddr;
    bit          chk_rd;
    logic [7:0]  rd;
  } vec_t;
  vec_t vecs [9];
  spi_regfile_periph dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_strobe) n_wr++;
    if (frame_err) n_err++;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse(input logic b, output logic s);
    copi = b;
    repeat (5) @(negedge clk);
    s = cipo;
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask
  task automatic frame(input logic [15:0] tx, input int nbits, input int gap, output logic [15:0] rx);
    logic s;
    rx = '0;
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      pulse(i < 16 ? tx[15-i] : 1'b1, s);
      if (i < 16) rx[15-i] = s;
    end
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask
  initial begin
    logic [15:0] rx;
    logic        s;
    int          w0, e0;
    vecs[0] = '{tx:16'h84A5, nbits:16, regs:40'hA5_00_00_00_00, wr:1, err:0, waddr:7'd4, chk_rd:0, rd:8'h00};
    vecs[1] = '{tx:16'h803C, nbits:16, regs:40'hA5_00_00_00_3C, wr:1, err:0, waddr:7'd0, chk_rd:0, rd:8'h00};
    vecs[2] = '{tx:16'h0000, nbits:16, regs:40'hA5_00_00_00_3C, wr:0, err:0, waddr:7'd0, chk_rd:1, rd:8'h3C};
    vecs[3] = '{tx:16'h04FF, nbits:16, regs:40'hA5_00_00_00_3C, wr:0, err:0, waddr:7'd0, chk_rd:1, rd:8'hA5};
    vecs[4] = '{tx:16'h8477, nbits:10, regs:40'hA5_00_00_00_3C, wr:0, err:1, waddr:7'd0, chk_rd:0, rd:8'h00};
    vecs[5] = '{tx:16'h85FF, nbits:16, regs:40'hA5_00_00_00_3C, wr:0, err:1, waddr:7'd0, chk_rd:0, rd:8'h00};
    vecs[6] = '{tx:16'h0500, nbits:16, regs:40'hA5_00_00_00_3C, wr:0, err:0, waddr:7'd0, chk_rd:1, rd:8'h00};
    vecs[7] = '{tx:16'h8211, nbits:5,  regs:40'hA5_00_00_00_3C, wr:0, err:1, waddr:7'd0, chk_rd:0, rd:8'h00};
    vecs[8] = '{tx:16'h0400, nbits:16, regs:40'hA5_00_00_00_3C, wr:0, err:0, waddr:7'd0, chk_rd:1, rd:8'hA5};
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst regs", regs_flat, 0);
    check("rst cipo", cipo, 0);
    check("rst cipo_oe", cipo_oe, 0);
    check("rst wr_strobe", wr_strobe, 0);
    check("rst frame_err", frame_err, 0);
    check("rst wr_addr", wr_addr, 0);
    for (int v = 0; v < 9; v++) begin
      w0 = n_wr;
      e0 = n_err;
      frame(vecs[v].tx, vecs[v].nbits, 10, rx);
      check($sformatf("v%0d regs", v), regs_flat, vecs[v].regs);
      check($sformatf("v%0d strobes", v), n_wr - w0, vecs[v].wr);
      check($sformatf("v%0d errs", v), n_err - e0, vecs[v].err);
      check($sformatf("v%0d wr_addr", v), wr_addr, vecs[v].waddr);
      if (vecs[v].chk_rd) check($sformatf("v%0d read", v), rx[7:0], vecs[v].rd);
    end
    w0 = n_wr;
    e0 = n_err;
    frame(16'h8111, 16, 4, rx);
    frame(16'h8322, 20, 10, rx);
    check("b2b regs", regs_flat, 40'hA5_22_00_11_3C);
    check("b2b strobes", n_wr - w0, 2);
    check("b2b errs", n_err - e0, 0);
    check("b2b wr_addr", wr_addr, 3);
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 11; i++) pulse(rx[15-i] ^ (i == 0), s);
    copi = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    check("mid cipo_oe", cipo_oe, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst regs", regs_flat, 0);
    check("mrst cipo", cipo, 0);
    check("mrst cipo_oe", cipo_oe, 0);
    check("mrst wr_strobe", wr_strobe, 0);
    check("mrst frame_err", frame_err, 0);
    check("mrst wr_addr", wr_addr, 0);
    w0 = n_wr;
    e0 = n_err;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sclk = 1'b0;
    for (int i = 0; i < 8; i++) pulse(1'b1, s);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    check("post-rst regs", regs_flat, 0);
    check("post-rst strobes", n_wr - w0, 0);
    check("post-rst errs", n_err - e0, 0);
    frame(16'h8266, 16, 10, rx);
    check("fresh regs", regs_flat, 40'h00_00_66_00_00);
    check("fresh strobes", n_wr - w0, 1);
    check("fresh wr_addr", wr_addr, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
